transpose_buffer: RTL and testbench

- Sits directly downstream of the first-pass coefficient permutation stage in the 2D DCT-II datapath, and upstream of the second-pass (row) transform.
- Collects one L-point block (L = 4/8/16/32), one permuted 1D-transform output row per accepted beat, then emits the block column by column.
- The second pass therefore sees transposed data.
- Both sides use valid/ready handshakes.

---
 rtl/transpose_buffer_if.sv | 27 ++
 rtl/transpose_buffer.sv | 93 +++++++++
 tb/tb_transpose_buffer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/transpose_buffer_if.sv
// Row-in / column-out bus of the DCT transpose buffer.
// slave is the buffer's view of the bus; master is the view of the producer and consumer around it.
interface transpose_buffer_if #(
    parameter int W    = 16,
    parameter int MAXP = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_n;
    logic [W*MAXP-1:0] in_y;
    logic              out_valid;
    logic              out_ready;
    logic [W*MAXP-1:0] out_y;
    logic [1:0]        out_n;
    logic [4:0]        out_col;
    logic              out_last;

    modport master (
        output in_valid, in_n, in_y, out_ready,
        input  in_ready, out_valid, out_y, out_n, out_col, out_last
    );

    modport slave (
        input  in_valid, in_n, in_y, out_ready,
        output in_ready, out_valid, out_y, out_n, out_col, out_last
    );
endinterface

// File: rtl/transpose_buffer.sv
// Single-bank transpose buffer: fills an LxL block row by row, then drains it column by column.
// Both sides are valid/ready: a beat moves on a rising edge where valid && ready; a stalled source holds its data.
module transpose_buffer #(
    parameter int W    = 16,
    parameter int MAXP = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    transpose_buffer_if.slave    bus,
    output logic                 dbg_state
);
    localparam int CW = $clog2(MAXP);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_cnt, col_cnt;
    logic [1:0]      n_lat;
    logic [1:0]      eff_n;
    logic            in_fire, out_fire, last_row, last_col;
    logic [W-1:0]    mem [MAXP][MAXP];

    function automatic logic [CW-1:0] last_idx(input logic [1:0] n);
        case (n)
            2'd0:    return CW'(3);
            2'd1:    return CW'(7);
            2'd2:    return CW'(15);
            default: return CW'(31);
        endcase
    endfunction

    // The size code only counts on the first row; later rows use the latched copy.
    assign eff_n    = (row_cnt == '0) ? bus.in_n : n_lat;
    assign in_fire  = bus.in_valid && (state_q == FILL);
    assign out_fire = bus.out_ready && (state_q == DRAIN);
    assign last_row = (row_cnt == last_idx(eff_n));
    assign last_col = (state_q == DRAIN) && (col_cnt == last_idx(n_lat));
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_fire && last_row) state_d = DRAIN;
            DRAIN:   if (out_fire && last_col) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
            n_lat   <= '0;
        end else begin
            if (in_fire) begin
                if (row_cnt == '0) n_lat <= bus.in_n;
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end
            if (out_fire) col_cnt <= last_col ? '0 : col_cnt + 1'b1;
        end
    end

    // Storage carries no reset; every location read in a drain was written by that block's fill.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int k = 0; k < MAXP; k++) begin
                if (CW'(k) <= last_idx(eff_n))
                    mem[row_cnt][k] <= bus.in_y[W*MAXP-1-W*k -: W];
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == FILL);
        bus.out_valid = (state_q == DRAIN);
        bus.out_n     = n_lat;
        bus.out_col   = 5'(col_cnt);
        bus.out_last  = last_col;
        bus.out_y     = '0;
        // Rows beyond L are forced to zero so a smaller block never exposes an older, larger one.
        if (state_q == DRAIN) begin
            for (int r = 0; r < MAXP; r++) begin
                if (CW'(r) <= last_idx(n_lat))
                    bus.out_y[W*MAXP-1-W*r -: W] = mem[r][col_cnt];
            end
        end
    end
endmodule

// File: tb/tb_transpose_buffer.sv
// Directed bench for transpose_buffer: hand-written row patterns and their transposed columns.
module tb_transpose_buffer;
    localparam int W    = 16;
    localparam int MAXP = 32;
    localparam int BW   = W * MAXP;

    logic clk = 1'b0;
    logic rst_n;
    logic dbg_state;

    logic [BW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    transpose_buffer_if #(.W(W), .MAXP(MAXP)) bus ();

    transpose_buffer #(.W(W), .MAXP(MAXP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Row r, lane k of each stimulus pattern.
    function automatic logic [W-1:0] row_lane(input int pat, input int r, input int k);
        case (pat)
            1:       return (k < 4) ? 16'(16 * r + k) : 16'hDEAD;
            2:       return 16'((r - k) * 100);
            3:       return 16'(32'h8000 | (r << 8) | k);
            4:       return 16'(32'h4000 + r * 32 + k);
            5:       return 16'(-(r * 16 + k));
            default: return 16'(32'h7000 + r * 4 + k);
        endcase
    endfunction

    // Expected column c, lane r: the element at row r, column c of the block.
    function automatic logic [W-1:0] col_lane(input int pat, input int c, input int r);
        case (pat)
            1:       return 16'(16 * r + c);
            2:       return 16'((r - c) * 100);
            3:       return 16'(32'h8000 | (r << 8) | c);
            4:       return 16'(32'h4000 + r * 32 + c);
            5:       return 16'(-(r * 16 + c));
            default: return 16'(32'h7000 + r * 4 + c);
        endcase
    endfunction

    function automatic logic [BW-1:0] mk_row(input int pat, input int r);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < MAXP; k++) v[BW-1-W*k -: W] = row_lane(pat, r, k);
        return v;
    endfunction

    function automatic logic [BW-1:0] mk_col(input int pat, input int c, input int l);
        logic [BW-1:0] v;
        v = '0;
        for (int r = 0; r < l; r++) v[BW-1-W*r -: W] = col_lane(pat, c, r);
        return v;
    endfunction

    task automatic send_block(input int pat, input int l, input logic [1:0] n0, input logic [1:0] nr);
        int t;
        for (int r = 0; r < l; r++) begin
            bus.in_valid = 1'b1;
            bus.in_n     = (r == 0) ? n0 : nr;
            bus.in_y     = mk_row(pat, r);
            t = 0;
            while (!bus.in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (!bus.in_ready) begin
                chk("in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            chk("fill_out_valid", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("first_col_latency", bus.out_valid, 1);
    endtask

    task automatic drain_block(input int pat, input int l, input logic [1:0] exp_n,
                               input int stall_col, input int stall_len, input int abort_col);
        logic [BW-1:0] e;
        int t;
        for (int c = 0; c < l; c++) exp_q.push_back(mk_col(pat, c, l));
        bus.out_ready = 1'b1;
        for (int c = 0; c < l; c++) begin
            t = 0;
            while (!bus.out_valid && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (!bus.out_valid) begin
                chk("out_valid_timeout", 0, 1);
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            chk("col_y", bus.out_y, e);
            chk("col_idx", bus.out_col, c);
            chk("col_last", bus.out_last, c == l - 1);
            chk("col_n", bus.out_n, exp_n);
            chk("drain_in_ready", bus.in_ready, 0);
            if (c == abort_col) begin
                bus.out_ready = 1'b0;
                exp_q.delete();
                return;
            end
            if (c == stall_col) begin
                bus.out_ready = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    chk("stall_y", bus.out_y, e);
                    chk("stall_col", bus.out_col, c);
                    chk("stall_last", bus.out_last, c == l - 1);
                end
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("end_out_valid", bus.out_valid, 0);
        chk("end_in_ready", bus.in_ready, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_y"}, bus.out_y, 0);
        chk({tag, "_out_col"}, bus.out_col, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_n      = 2'd0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        #1;
        check_idle("reset");
        chk("reset_out_n", bus.out_n, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 4-point block, lanes beyond 4 carry filler that must not appear.
        send_block(1, 4, 2'd0, 2'd0);
        chk("drain_state", dbg_state, 1);
        drain_block(1, 4, 2'd0, -1, 0, -1);

        // 32-point block with signed values.
        send_block(2, 32, 2'd3, 2'd3);
        drain_block(2, 32, 2'd3, -1, 0, -1);

        // 8-point block after the 32-point one; in_n changes on later rows are ignored.
        send_block(3, 8, 2'd1, 2'd2);
        drain_block(3, 8, 2'd1, -1, 0, -1);

        // 8-point block: consumer stalls on column 3, producer holds the next block's row 0 throughout.
        send_block(4, 8, 2'd1, 2'd1);
        bus.in_valid = 1'b1;
        bus.in_n     = 2'd2;
        bus.in_y     = mk_row(5, 0);
        drain_block(4, 8, 2'd1, 3, 5, -1);

        // 16-point block interrupted by reset at column 2.
        send_block(5, 16, 2'd2, 2'd2);
        drain_block(5, 16, 2'd2, -1, 0, 2);
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send_block(6, 4, 2'd0, 2'd0);
        drain_block(6, 4, 2'd0, -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
